// File: rtl/clk_div_cfg_if.sv
// Ratio request channel between the control path and the divider config front-end.
// The control path drives valid/ratio; the front-end answers with ready.
interface clk_div_cfg_if #(
    parameter int WIDTH = 4
);
    logic             i_cfg_valid;
    logic [WIDTH-1:0] i_cfg_ratio;
    logic             o_cfg_ready;

    modport master (output i_cfg_valid, output i_cfg_ratio, input  o_cfg_ready);
    modport slave  (input  i_cfg_valid, input  i_cfg_ratio, output o_cfg_ready);
endinterface

// File: rtl/clk_div_cfg.sv
// Divider configuration front-end: owns the divide ratio and enable, and defers
// ratio changes while running to the divided clock's falling edge (or a timeout).
//
// state | meaning
// IDLE  | divider stopped, accepted ratios load straight into o_div_ratio
// RUN   | divider running, ratio frozen, an accepted ratio moves to PEND
// PEND  | ratio waiting for a falling edge of i_div_clk, timeout or disable
module clk_div_cfg #(
    parameter int WIDTH         = 4,
    parameter int DEFAULT_RATIO = 8
) (
    input  logic             i_clk_ref,
    input  logic             i_rst,
    input  logic             i_enable,
    clk_div_cfg_if.slave     cfg,
    input  logic             i_div_clk,
    output logic [WIDTH-1:0] o_div_ratio,
    output logic             o_clk_en,
    output logic             o_busy,
    output logic             o_cfg_err,
    output logic             o_force
);
    localparam int               CNT_W     = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(DEFAULT_RATIO);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state;
    logic             div_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_ratio;
    logic             xfer;
    logic             ratio_ok;
    logic             fall;

    assign xfer     = cfg.i_cfg_valid && cfg.o_cfg_ready;
    assign ratio_ok = (cfg.i_cfg_ratio[WIDTH-1:1] != '0);
    assign fall     = div_q && !i_div_clk;

    always_ff @(posedge i_clk_ref or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            div_q           <= 1'b0;
            cnt             <= '0;
            pend_ratio      <= RATIO_RST;
            o_div_ratio     <= RATIO_RST;
            o_clk_en        <= 1'b0;
            cfg.o_cfg_ready <= 1'b1;
            o_busy          <= 1'b0;
            o_cfg_err       <= 1'b0;
            o_force         <= 1'b0;
        end else begin
            div_q     <= i_div_clk;
            o_cfg_err <= xfer && !ratio_ok;
            o_force   <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer && ratio_ok) o_div_ratio <= cfg.i_cfg_ratio;
                    if (i_enable) begin
                        state    <= RUN;
                        o_clk_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (!i_enable) begin
                        // divider is stopping, so a same-cycle ratio is safe to apply now
                        if (xfer && ratio_ok) o_div_ratio <= cfg.i_cfg_ratio;
                        state    <= IDLE;
                        o_clk_en <= 1'b0;
                    end else if (xfer && ratio_ok) begin
                        pend_ratio      <= cfg.i_cfg_ratio;
                        cnt             <= '0;
                        state           <= PEND;
                        cfg.o_cfg_ready <= 1'b0;
                        o_busy          <= 1'b1;
                    end
                end
                PEND: begin
                    if (!i_enable || fall || cnt == CNT_MAX) begin
                        o_div_ratio     <= pend_ratio;
                        cnt             <= '0;
                        cfg.o_cfg_ready <= 1'b1;
                        o_busy          <= 1'b0;
                        if (!i_enable) begin
                            state    <= IDLE;
                            o_clk_en <= 1'b0;
                        end else begin
                            state   <= RUN;
                            o_force <= !fall;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
